// File: rtl/kf76489_pkg.sv
// Shared types for the KF76489 CPU register decoder: FSM states and the
// 3-bit latched register address with its eight named values.
package kf76489_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STROBE  = 2'd1,
      ST_BUSY    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   typedef logic [2:0] reg_addr_t;

   localparam reg_addr_t ADDR_TONE0_FREQ  = 3'b000;
   localparam reg_addr_t ADDR_TONE0_ATTEN = 3'b001;
   localparam reg_addr_t ADDR_TONE1_FREQ  = 3'b010;
   localparam reg_addr_t ADDR_TONE1_ATTEN = 3'b011;
   localparam reg_addr_t ADDR_TONE2_FREQ  = 3'b100;
   localparam reg_addr_t ADDR_TONE2_ATTEN = 3'b101;
   localparam reg_addr_t ADDR_NOISE_CTRL  = 3'b110;
   localparam reg_addr_t ADDR_NOISE_ATTEN = 3'b111;

   // TI bit order: bit 0 is the MSB, so the address field reads bits 1..3.
   function automatic reg_addr_t latch_address(input logic [7:0] byte_in);
      return {byte_in[1], byte_in[2], byte_in[3]};
   endfunction

endpackage

// File: rtl/kf76489_sync2.sv
// Two-flop synchronizer for an asynchronous CPU control line, with a
// parameterized value loaded on reset.
module kf76489_sync2 #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta     <= RESET_VALUE;
         sync_out <= RESET_VALUE;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/kf76489_register_decoder.sv
// CPU write interface of the KF76489: captures a byte per write, decodes it
// into one register write strobe and holds READY low for the chip wait time.
module kf76489_register_decoder
   import kf76489_pkg::*;
#(
   parameter int WAIT_CYCLES = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clock_enable,
   input  logic       chip_select_n,
   input  logic       write_enable_n,
   input  logic [7:0] data_bus_in,
   output logic       ready,
   output logic [7:0] internal_data_bus,
   output logic [2:0] write_tone_frequency_low,
   output logic [2:0] write_tone_frequency_high,
   output logic [2:0] write_tone_attenuation,
   output logic       write_noise_control,
   output logic       write_noise_attenuation
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   logic      chip_select_sync;
   logic      write_enable_sync;
   logic      write_request;
   state_t    state;
   reg_addr_t address;
   reg_addr_t next_address;
   logic [CW-1:0] wait_count;
   logic [2:0] next_freq_low;
   logic [2:0] next_freq_high;
   logic [2:0] next_atten;
   logic       next_noise_ctrl;
   logic       next_noise_atten;

   kf76489_sync2 #(.RESET_VALUE(1'b1)) u_sync_cs (
      .clock    (clock),
      .reset    (reset),
      .async_in (chip_select_n),
      .sync_out (chip_select_sync)
   );

   kf76489_sync2 #(.RESET_VALUE(1'b1)) u_sync_we (
      .clock    (clock),
      .reset    (reset),
      .async_in (write_enable_n),
      .sync_out (write_enable_sync)
   );

   assign write_request = ~chip_select_sync & ~write_enable_sync;

   // Decode the strobe the incoming byte will fire against the address it leaves latched.
   always_comb begin
      next_address     = data_bus_in[0] ? latch_address(data_bus_in) : address;
      next_freq_low    = 3'b000;
      next_freq_high   = 3'b000;
      next_atten       = 3'b000;
      next_noise_ctrl  = 1'b0;
      next_noise_atten = 1'b0;
      case (next_address)
         ADDR_NOISE_CTRL:  next_noise_ctrl  = 1'b1;
         ADDR_NOISE_ATTEN: next_noise_atten = 1'b1;
         default: begin
            if (next_address[0]) begin
               next_atten[next_address[2:1]] = 1'b1;
            end else if (data_bus_in[0]) begin
               next_freq_low[next_address[2:1]] = 1'b1;
            end else begin
               next_freq_high[next_address[2:1]] = 1'b1;
            end
         end
      endcase
   end

   // Write handshake FSM; strobes are registered so they are high exactly during STROBE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                     <= ST_IDLE;
         ready                     <= 1'b1;
         internal_data_bus         <= 8'h00;
         address                   <= ADDR_TONE0_FREQ;
         wait_count                <= '0;
         write_tone_frequency_low  <= 3'b000;
         write_tone_frequency_high <= 3'b000;
         write_tone_attenuation    <= 3'b000;
         write_noise_control       <= 1'b0;
         write_noise_attenuation   <= 1'b0;
      end else begin
         write_tone_frequency_low  <= 3'b000;
         write_tone_frequency_high <= 3'b000;
         write_tone_attenuation    <= 3'b000;
         write_noise_control       <= 1'b0;
         write_noise_attenuation   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (write_request) begin
                  internal_data_bus         <= data_bus_in;
                  address                   <= next_address;
                  write_tone_frequency_low  <= next_freq_low;
                  write_tone_frequency_high <= next_freq_high;
                  write_tone_attenuation    <= next_atten;
                  write_noise_control       <= next_noise_ctrl;
                  write_noise_attenuation   <= next_noise_atten;
                  ready                     <= 1'b0;
                  state                     <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               wait_count <= CW'(WAIT_CYCLES - 1);
               state      <= ST_BUSY;
            end
            ST_BUSY: begin
               if (clock_enable) begin
                  if (wait_count == '0) begin
                     ready <= 1'b1;
                     state <= ST_RELEASE;
                  end else begin
                     wait_count <= wait_count - 1'b1;
                  end
               end
            end
            ST_RELEASE: begin
               // A held write must be released before the next one is accepted.
               if (!write_request) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kf76489_register_decoder.sv
// Directed plus random writes against an address/strobe model kept in the bench.
module tb_kf76489_register_decoder;

   localparam int WAIT = 32;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clock_enable = 1'b0;
   logic       chip_select_n = 1'b1;
   logic       write_enable_n = 1'b1;
   logic [7:0] data_bus_in = 8'h00;
   logic       ready;
   logic [7:0] internal_data_bus;
   logic [2:0] write_tone_frequency_low;
   logic [2:0] write_tone_frequency_high;
   logic [2:0] write_tone_attenuation;
   logic       write_noise_control;
   logic       write_noise_attenuation;

   int checks = 0;
   int failures = 0;
   int model_addr = 0;

   kf76489_register_decoder #(.WAIT_CYCLES(WAIT)) dut (
      .clock                     (clock),
      .reset                     (reset),
      .clock_enable              (clock_enable),
      .chip_select_n             (chip_select_n),
      .write_enable_n            (write_enable_n),
      .data_bus_in               (data_bus_in),
      .ready                     (ready),
      .internal_data_bus         (internal_data_bus),
      .write_tone_frequency_low  (write_tone_frequency_low),
      .write_tone_frequency_high (write_tone_frequency_high),
      .write_tone_attenuation    (write_tone_attenuation),
      .write_noise_control       (write_noise_control),
      .write_noise_attenuation   (write_noise_attenuation)
   );

   always #5 clock = ~clock;

   function automatic logic [10:0] strobes();
      return {write_tone_frequency_low, write_tone_frequency_high,
              write_tone_attenuation, write_noise_control, write_noise_attenuation};
   endfunction

   // Bit position in the strobes() vector for a write to addr.
   function automatic logic [10:0] expected_vec(input bit is_latch, input int addr);
      int ch;
      int pos;
      ch = addr / 2;
      if (ch == 3)          pos = (addr % 2 == 1) ? 0 : 1;
      else if (addr % 2)    pos = 2 + ch;
      else if (is_latch)    pos = 8 + ch;
      else                  pos = 5 + ch;
      return 11'(1 << pos);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Raise a write and wait for its strobe; checks strobe, bus and one-cycle width.
   task automatic start_write(input logic [7:0] d);
      bit got;
      logic [10:0] exp;
      if (d[0]) model_addr = d[1] * 4 + d[2] * 2 + d[3];
      exp = expected_vec(d[0], model_addr);
      data_bus_in = d;
      chip_select_n = 1'b0;
      write_enable_n = 1'b0;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (strobes() != 11'd0) got = 1;
      end
      check("strobe", 32'(strobes()), 32'(exp));
      check("data_bus", 32'(internal_data_bus), 32'(d));
      check("ready_low", 32'(ready), 32'd0);
      clock_enable = 1'b0;
      tick();
      check("strobe_width", 32'(strobes()), 32'd0);
   endtask

   task automatic do_write(input logic [7:0] d, input int period, input int stall);
      int ticks;
      int cyc;
      bit seen;
      start_write(d);
      seen = 0;
      for (int i = 0; i < stall; i++) begin
         tick();
         if (strobes() != 11'd0 || ready !== 1'b0) seen = 1;
      end
      if (stall > 0) check("stall_busy", 32'(seen), 32'd0);
      ticks = 0;
      cyc = 0;
      while (ready === 1'b0 && cyc < WAIT * period + 20) begin
         clock_enable = ((cyc % period) == period - 1);
         tick();
         if (clock_enable) ticks++;
         if (strobes() != 11'd0) seen = 1;
         cyc++;
      end
      clock_enable = 1'b0;
      check("ce_ticks", 32'(ticks), 32'(WAIT));
      for (int i = 0; i < 10; i++) begin
         tick();
         if (strobes() != 11'd0) seen = 1;
      end
      check("no_repeat", 32'(seen), 32'd0);
      chip_select_n = 1'b1;
      write_enable_n = 1'b1;
      repeat (5) tick();
      check("ready_after", 32'(ready), 32'd1);
   endtask

   initial begin
      bit seen;
      #12;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_strobes", 32'(strobes()), 32'd0);
      check("rst_bus", 32'(internal_data_bus), 32'd0);
      reset = 1'b0;
      repeat (3) tick();

      do_write(8'h05, 1, 0);
      do_write(8'hFC, 1, 0);
      check("addr_kept", 32'(model_addr), 32'd2);
      do_write(8'hA7, 2, 0);
      check("bus_b5", 32'(internal_data_bus[5]), 32'd1);
      check("bus_b76", 32'(internal_data_bus[7:6]), 32'd2);
      do_write(8'h09, 16, 0);
      do_write(8'h40, 1, 300);

      // Reset in the middle of BUSY abandons the write.
      start_write(8'h0F);
      clock_enable = 1'b1;
      repeat (5) tick();
      chip_select_n = 1'b1;
      write_enable_n = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_ready", 32'(ready), 32'd1);
      check("mid_rst_strobes", 32'(strobes()), 32'd0);
      tick();
      reset = 1'b0;
      model_addr = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (strobes() != 11'd0) seen = 1;
      end
      clock_enable = 1'b0;
      check("post_rst_quiet", 32'(seen), 32'd0);
      do_write(8'hFC, 1, 0);

      for (int n = 0; n < 20; n++) begin
         do_write(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kf76489_register_decoder.md
KF76489_REGISTER_DECODER -- requirements
Module: kf76489_register_decoder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 32, meaning the number of clock_enable ticks READY stays low per accepted write.
REQ-002 The block SHALL have port clock, input, 1, system clock.
REQ-003 The block SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have port clock_enable, input, 1, chip clock tick qualifier.
REQ-005 The block SHALL have port chip_select_n, input, 1, CPU CE, active-low, asynchronous to clock.
REQ-006 The block SHALL have port write_enable_n, input, 1, CPU WE, active-low, asynchronous to clock.
REQ-007 The block SHALL have port data_bus_in, input, 8, CPU byte in TI numbering: bit 0 = latch flag, bit 7 = LSB.
REQ-008 The block SHALL have port ready, output, 1, CPU READY, high = accepting writes.
REQ-009 The block SHALL have port internal_data_bus, output, 8, captured byte, bit-for-bit copy of data_bus_in.
REQ-010 The block SHALL have port write_tone_frequency_low, output, 3, per-tone-channel low-nibble strobe.
REQ-011 The block SHALL have port write_tone_frequency_high, output, 3, per-tone-channel high-6-bit strobe.
REQ-012 The block SHALL have port write_tone_attenuation, output, 3, per-tone-channel attenuation strobe.
REQ-013 The block SHALL have ports write_noise_control and write_noise_attenuation, output, 1 each, noise register strobes.

Function
REQ-014 The block SHALL synchronize chip_select_n and write_enable_n through two flip-flops each; write request = both synchronized signals low.
REQ-015 The block SHALL implement states IDLE, STROBE, BUSY and RELEASE.
REQ-016 In IDLE with write request, the block SHALL capture data_bus_in into internal_data_bus and enter STROBE next cycle.
REQ-017 In STROBE, the block SHALL assert exactly one write strobe for one clock cycle, load the wait counter with WAIT_CYCLES-1, and enter BUSY.
REQ-018 In BUSY, the block SHALL decrement the counter only on clock_enable and enter RELEASE on a clock_enable tick with the counter at 0.
REQ-019 In RELEASE, the block SHALL return to IDLE once write request is deasserted; a held write is never accepted twice.
REQ-020 ready SHALL be registered, 1 in IDLE and RELEASE, and 0 in STROBE and BUSY.
REQ-021 A latch byte (bit 0 = 1) SHALL update the 3-bit latched address to {bit1, bit2, bit3} = {channel[1:0], type}, with type 1 = attenuation.
REQ-022 The address SHALL decode as: 000/010/100 = tone0/1/2 frequency; 001/011/101 = tone0/1/2 attenuation; 110 = noise control; 111 = noise attenuation.
REQ-023 A latch byte SHALL strobe the newly latched register; a frequency address SHALL use write_tone_frequency_low[channel].
REQ-024 A data byte (bit 0 = 0) SHALL NOT change the latched address and SHALL strobe the currently latched register.
REQ-025 For a data byte to a frequency address, the block SHALL use write_tone_frequency_high[channel]; other addresses SHALL use their normal strobe.
REQ-026 chip_select_n rising during BUSY SHALL NOT abort the wait; BUSY always completes.
REQ-027 With clock_enable held low, BUSY SHALL persist indefinitely and no strobe SHALL repeat.

Reset
REQ-028 Reset SHALL set: state IDLE; ready 1; all strobes 0; internal_data_bus 8'h00; latched address 3'b000; wait counter 0; synchronizers 1.
REQ-029 Reset asserted mid-BUSY SHALL abandon the write, leaving strobes already issued effective and issuing no further strobe.

Structure
REQ-030 A shared package kf76489_pkg SHALL hold the state enum, the 3-bit register-address typedef and its eight named address constants.
REQ-031 The block SHALL instantiate one sub-module, kf76489_sync2, a 2-flop synchronizer with parameterized reset value, used for both CPU control inputs.

Verification
REQ-032 Write 8'h05 (latch tone1 freq) -> write_tone_frequency_low = 3'b010 for one cycle; internal_data_bus = 8'h05.
REQ-033 Write 8'h05 then 8'hFC -> second write asserts write_tone_frequency_high = 3'b010 for one cycle; address stays 3'b010.
REQ-034 Write 8'hA7 -> write_noise_control pulses once; internal_data_bus[5] = 1, [7:6] = 2'b10.
REQ-035 Write 8'h09, clock_enable every 16 clocks -> write_tone_attenuation = 3'b001; ready low for exactly 32 clock_enable ticks; WE_N held low afterward yields no second strobe.
REQ-036 Reset pulsed during BUSY after 8'h0F -> ready = 1 within one cycle, no further strobe; next data byte 8'hFC strobes write_tone_frequency_high[0] (address 3'b000).
